// File: rtl/cmd_fetch_seq.sv
// Command fetch sequencer: walks a command-buffer range, retries dropped reads,
// and feeds a 2-entry FIFO to the execution engine. Optional loop mode: CMD_SEQ_LOOP_EN.
module cmd_fetch_seq #(
    parameter int unsigned CMD_WIDTH        = 64,
    parameter int unsigned TRANS_ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH        = 8,
    parameter int unsigned MAX_CMDS         = 128
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        cfg_start,
    input  logic [TRANS_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [CNT_WIDTH-1:0]        cfg_cmd_count,
    input  logic                        cfg_abort,
`ifdef CMD_SEQ_LOOP_EN
    input  logic                        cfg_loop,
`endif
    output logic                        seq_busy,
    output logic                        seq_done,
    output logic                        seq_err,
    output logic                        seq_abort_ack,
    output logic                        cmd_rd_en,
    output logic [TRANS_ADDR_WIDTH-1:0] cmd_addr,
    input  logic                        cmd_rd_valid,
    input  logic [CMD_WIDTH-1:0]        cmd_out,
    output logic                        exe_valid,
    output logic [CMD_WIDTH-1:0]        exe_cmd,
    input  logic                        exe_ready
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAIN, DONE} state_t;

    localparam logic [CNT_WIDTH:0] MAX_C = (CNT_WIDTH+1)'(MAX_CMDS);

    state_t                      state, state_nxt;
    logic [TRANS_ADDR_WIDTH-1:0] ptr;
    logic [CNT_WIDTH-1:0]        left;
    logic                        start_bad;
    logic                        load, advance, reload, push, pop, flush;
    logic                        err_nxt, ack_nxt;

    logic [CMD_WIDTH-1:0]        mem [2];
    logic                        rd_ptr, wr_ptr;
    logic [1:0]                  fifo_cnt;

`ifdef CMD_SEQ_LOOP_EN
    logic                        loop_q;
    logic [TRANS_ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]        count_q;
`endif

    assign start_bad = (cfg_cmd_count == '0) || ({1'b0, cfg_cmd_count} > MAX_C) || cfg_base_addr[0];
    assign exe_valid = (fifo_cnt != 2'd0);
    assign exe_cmd   = mem[rd_ptr];
    assign pop       = exe_valid && exe_ready;
    assign cmd_addr  = ptr;
    assign seq_busy  = (state == FETCH) || (state == WAIT) || (state == DRAIN);
    assign seq_done  = (state == DONE);

    always_comb begin
        state_nxt = state;
        cmd_rd_en = 1'b0;
        load      = 1'b0;
        advance   = 1'b0;
        reload    = 1'b0;
        push      = 1'b0;
        flush     = 1'b0;
        err_nxt   = 1'b0;
        ack_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    if (start_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                // Room exists if not full, or a pop frees a slot this cycle.
                if ((fifo_cnt != 2'd2) || pop) begin
                    cmd_rd_en = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = FETCH;
                if (cmd_rd_valid) begin
                    push    = 1'b1;
                    advance = 1'b1;
                    if (left == CNT_WIDTH'(1)) begin
`ifdef CMD_SEQ_LOOP_EN
                        reload = loop_q;
                        if (!loop_q) state_nxt = DRAIN;
`else
                        state_nxt = DRAIN;
`endif
                    end
                end
            end
            DRAIN: begin
                if (fifo_cnt == 2'd0) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort overrides everything: in-flight data is dropped and the FIFO flushed.
        if ((state != IDLE) && cfg_abort) begin
            state_nxt = IDLE;
            cmd_rd_en = 1'b0;
            push      = 1'b0;
            advance   = 1'b0;
            reload    = 1'b0;
            flush     = 1'b1;
            ack_nxt   = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            ptr           <= '0;
            left          <= '0;
            seq_err       <= 1'b0;
            seq_abort_ack <= 1'b0;
        end else begin
            state         <= state_nxt;
            seq_err       <= err_nxt;
            seq_abort_ack <= ack_nxt;
            if (load) begin
                ptr  <= cfg_base_addr;
                left <= cfg_cmd_count;
            end else if (advance) begin
`ifdef CMD_SEQ_LOOP_EN
                if (reload) begin
                    ptr  <= base_q;
                    left <= count_q;
                end else begin
                    ptr  <= ptr + TRANS_ADDR_WIDTH'(2);
                    left <= left - CNT_WIDTH'(1);
                end
`else
                ptr  <= ptr + TRANS_ADDR_WIDTH'(2);
                left <= left - CNT_WIDTH'(1);
`endif
            end
        end
    end

`ifdef CMD_SEQ_LOOP_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            loop_q  <= 1'b0;
            base_q  <= '0;
            count_q <= '0;
        end else if (load) begin
            loop_q  <= cfg_loop;
            base_q  <= cfg_base_addr;
            count_q <= cfg_cmd_count;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else if (flush) begin
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= cmd_out;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_fetch_seq.sv
// Directed bench for cmd_fetch_seq with a behavioural command-buffer model.
module tb_cmd_fetch_seq;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [7:0]  cfg_base_addr = '0;
    logic [7:0]  cfg_cmd_count = '0;
    logic        cfg_abort = 1'b0;
    logic        seq_busy, seq_done, seq_err, seq_abort_ack;
    logic        cmd_rd_en;
    logic [7:0]  cmd_addr;
    logic        cmd_rd_valid = 1'b0;
    logic [63:0] cmd_out = '0;
    logic        exe_valid;
    logic [63:0] exe_cmd;
    logic        exe_ready = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  rd_log[$];
    logic [63:0] got[$];
    int done_n = 0, err_n = 0, ack_n = 0;
    int rd_cnt = 0;
    int drop_idx = -1;

    cmd_fetch_seq #(.CMD_WIDTH(64), .TRANS_ADDR_WIDTH(8), .CNT_WIDTH(8), .MAX_CMDS(128)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
        .cfg_cmd_count(cfg_cmd_count), .cfg_abort(cfg_abort), .seq_busy(seq_busy),
        .seq_done(seq_done), .seq_err(seq_err), .seq_abort_ack(seq_abort_ack),
        .cmd_rd_en(cmd_rd_en), .cmd_addr(cmd_addr), .cmd_rd_valid(cmd_rd_valid),
        .cmd_out(cmd_out), .exe_valid(exe_valid), .exe_cmd(exe_cmd), .exe_ready(exe_ready)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] word(input logic [7:0] a);
        return {16'hC0DE, 8'h5A, a};
    endfunction

    function automatic logic [63:0] exp_cmd(input logic [7:0] a);
        logic [7:0] hi;
        hi = a + 8'd1;
        return {word(hi), word(a)};
    endfunction

    // Command buffer: answers one cycle after a read, optionally dropping read #drop_idx.
    always @(posedge i_clk) begin
        if (cmd_rd_en) begin
            cmd_rd_valid <= (rd_cnt != drop_idx);
            cmd_out      <= exp_cmd(cmd_addr);
            rd_cnt       <= rd_cnt + 1;
        end else begin
            cmd_rd_valid <= 1'b0;
        end
    end

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (cmd_rd_en) rd_log.push_back(cmd_addr);
            if (exe_valid && exe_ready) got.push_back(exe_cmd);
            if (seq_done) done_n++;
            if (seq_err) err_n++;
            if (seq_abort_ack) ack_n++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] base, input logic [7:0] cnt);
        cfg_base_addr = base;
        cfg_cmd_count = cnt;
        cfg_start = 1'b1;
        tick(1);
        cfg_start = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        tick(2);
        vectors++; if (seq_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b exp 0", seq_busy); end
        vectors++; if ({seq_done, seq_err, seq_abort_ack, cmd_rd_en} !== 4'b0) begin miscompares++; $display("FAIL reset_pulses: got %b exp 0000", {seq_done, seq_err, seq_abort_ack, cmd_rd_en}); end
        vectors++; if (exe_valid !== 1'b0) begin miscompares++; $display("FAIL reset_exe_valid: got %b exp 0", exe_valid); end
        vectors++; if (exe_cmd !== 64'h0) begin miscompares++; $display("FAIL reset_exe_cmd: got %h exp 0", exe_cmd); end
        vectors++; if (cmd_addr !== 8'h00) begin miscompares++; $display("FAIL reset_cmd_addr: got %h exp 00", cmd_addr); end
        i_rst = 1'b0;
        tick(1);
    endtask

    task automatic test_basic;
        int r0 = rd_log.size(), g0 = got.size(), d0 = done_n;
        exe_ready = 1'b1;
        pulse_start(8'h10, 8'd3);
        vectors++; if ({seq_busy, cmd_rd_en} !== 2'b11) begin miscompares++; $display("FAIL basic_first_read: busy,rd_en got %b exp 11", {seq_busy, cmd_rd_en}); end
        vectors++; if (cmd_addr !== 8'h10) begin miscompares++; $display("FAIL basic_first_addr: got %h exp 10", cmd_addr); end
        tick(1);
        vectors++; if ({cmd_rd_en, exe_valid} !== 2'b00) begin miscompares++; $display("FAIL basic_wait: rd_en,valid got %b exp 00", {cmd_rd_en, exe_valid}); end
        tick(1);
        vectors++; if (exe_valid !== 1'b1 || exe_cmd !== exp_cmd(8'h10)) begin miscompares++; $display("FAIL basic_latency: valid %b cmd %h exp 1 %h", exe_valid, exe_cmd, exp_cmd(8'h10)); end
        tick(20);
        vectors++; if (rd_log.size() - r0 != 3) begin miscompares++; $display("FAIL basic_nreads: got %0d exp 3", rd_log.size() - r0); end
        for (int i = 0; i < 3; i++) begin
            logic [7:0] ea;
            ea = 8'h10 + 8'(2 * i);
            vectors++; if (rd_log[r0+i] !== ea) begin miscompares++; $display("FAIL basic_addr%0d: got %h exp %h", i, rd_log[r0+i], ea); end
            vectors++; if (got[g0+i] !== exp_cmd(ea)) begin miscompares++; $display("FAIL basic_cmd%0d: got %h exp %h", i, got[g0+i], exp_cmd(ea)); end
        end
        vectors++; if (got.size() - g0 != 3) begin miscompares++; $display("FAIL basic_ncmds: got %0d exp 3", got.size() - g0); end
        vectors++; if (done_n - d0 != 1) begin miscompares++; $display("FAIL basic_done: got %0d exp 1", done_n - d0); end
        vectors++; if (seq_busy !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b exp 0", seq_busy); end
    endtask

    task automatic test_errors;
        int r0 = rd_log.size(), e0 = err_n, a0 = ack_n;
        logic [7:0] bases [3];
        logic [7:0] cnts [3];
        bases[0] = 8'h10; cnts[0] = 8'd0;
        bases[1] = 8'h10; cnts[1] = 8'd129;
        bases[2] = 8'h11; cnts[2] = 8'd3;
        for (int i = 0; i < 3; i++) begin
            pulse_start(bases[i], cnts[i]);
            vectors++; if ({seq_err, seq_busy} !== 2'b10) begin miscompares++; $display("FAIL err_pulse%0d: err,busy got %b exp 10", i, {seq_err, seq_busy}); end
            tick(1);
            vectors++; if (seq_err !== 1'b0) begin miscompares++; $display("FAIL err_onecycle%0d: got %b exp 0", i, seq_err); end
        end
        cfg_abort = 1'b1;
        tick(1);
        cfg_abort = 1'b0;
        tick(3);
        vectors++; if (err_n - e0 != 3) begin miscompares++; $display("FAIL err_count: got %0d exp 3", err_n - e0); end
        vectors++; if (rd_log.size() != r0) begin miscompares++; $display("FAIL err_no_reads: got %0d exp %0d", rd_log.size(), r0); end
        vectors++; if (ack_n != a0) begin miscompares++; $display("FAIL idle_abort_ack: got %0d exp %0d", ack_n, a0); end
    endtask

    task automatic test_wrap;
        int r0 = rd_log.size(), g0 = got.size();
        exe_ready = 1'b1;
        pulse_start(8'hFE, 8'd2);
        tick(15);
        vectors++; if (rd_log.size() - r0 != 2 || rd_log[r0] !== 8'hFE || rd_log[r0+1] !== 8'h00) begin miscompares++; $display("FAIL wrap_addrs: n %0d first %h second %h exp 2 fe 00", rd_log.size() - r0, rd_log[r0], rd_log[r0+1]); end
        vectors++; if (got[g0] !== exp_cmd(8'hFE) || got[g0+1] !== exp_cmd(8'h00)) begin miscompares++; $display("FAIL wrap_cmds: got %h %h exp %h %h", got[g0], got[g0+1], exp_cmd(8'hFE), exp_cmd(8'h00)); end
    endtask

    task automatic test_backpressure;
        int r0 = rd_log.size(), g0 = got.size(), d0 = done_n, e0 = err_n;
        exe_ready = 1'b0;
        pulse_start(8'h40, 8'd4);
        tick(15);
        vectors++; if (rd_log.size() - r0 != 2) begin miscompares++; $display("FAIL bp_stall_reads: got %0d exp 2", rd_log.size() - r0); end
        vectors++; if (exe_valid !== 1'b1 || exe_cmd !== exp_cmd(8'h40)) begin miscompares++; $display("FAIL bp_head: valid %b cmd %h exp 1 %h", exe_valid, exe_cmd, exp_cmd(8'h40)); end
        pulse_start(8'h00, 8'd0);
        tick(2);
        vectors++; if (err_n != e0 || seq_busy !== 1'b1) begin miscompares++; $display("FAIL bp_busy_start: err %0d busy %b exp %0d 1", err_n, seq_busy, e0); end
        exe_ready = 1'b1;
        tick(20);
        vectors++; if (got.size() - g0 != 4) begin miscompares++; $display("FAIL bp_ncmds: got %0d exp 4", got.size() - g0); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] ea;
            ea = 8'h40 + 8'(2 * i);
            vectors++; if (got[g0+i] !== exp_cmd(ea)) begin miscompares++; $display("FAIL bp_cmd%0d: got %h exp %h", i, got[g0+i], exp_cmd(ea)); end
        end
        vectors++; if (done_n - d0 != 1) begin miscompares++; $display("FAIL bp_done: got %0d exp 1", done_n - d0); end
    endtask

    task automatic test_retry;
        int r0 = rd_log.size(), g0 = got.size();
        exe_ready = 1'b1;
        drop_idx = rd_cnt;
        pulse_start(8'h20, 8'd2);
        tick(20);
        drop_idx = -1;
        vectors++; if (rd_log.size() - r0 != 3) begin miscompares++; $display("FAIL retry_nreads: got %0d exp 3", rd_log.size() - r0); end
        vectors++; if (rd_log[r0] !== 8'h20 || rd_log[r0+1] !== 8'h20 || rd_log[r0+2] !== 8'h22) begin miscompares++; $display("FAIL retry_addrs: got %h %h %h exp 20 20 22", rd_log[r0], rd_log[r0+1], rd_log[r0+2]); end
        vectors++; if (got.size() - g0 != 2 || got[g0] !== exp_cmd(8'h20) || got[g0+1] !== exp_cmd(8'h22)) begin miscompares++; $display("FAIL retry_cmds: n %0d got %h %h exp 2 %h %h", got.size() - g0, got[g0], got[g0+1], exp_cmd(8'h20), exp_cmd(8'h22)); end
    endtask

    task automatic test_abort;
        int g0 = got.size(), d0 = done_n, a0 = ack_n;
        int budget = 0;
        exe_ready = 1'b1;
        pulse_start(8'h60, 8'd5);
        while (got.size() - g0 < 2 && budget < 40) begin
            tick(1);
            budget++;
        end
        vectors++; if (got.size() - g0 < 2) begin miscompares++; $display("FAIL abort_timeout: got %0d cmds exp 2", got.size() - g0); end
        cfg_abort = 1'b1;
        tick(1);
        cfg_abort = 1'b0;
        vectors++; if ({seq_abort_ack, seq_busy, exe_valid} !== 3'b100) begin miscompares++; $display("FAIL abort_state: ack,busy,valid got %b exp 100", {seq_abort_ack, seq_busy, exe_valid}); end
        tick(10);
        vectors++; if (ack_n - a0 != 1 || done_n != d0) begin miscompares++; $display("FAIL abort_pulses: ack %0d done %0d exp 1 0", ack_n - a0, done_n - d0); end
        vectors++; if (got.size() - g0 != 2 || got[g0+1] !== exp_cmd(8'h62)) begin miscompares++; $display("FAIL abort_delivered: n %0d last %h exp 2 %h", got.size() - g0, got[g0+1], exp_cmd(8'h62)); end
        g0 = got.size();
        pulse_start(8'h80, 8'd2);
        tick(15);
        vectors++; if (got.size() - g0 != 2 || got[g0] !== exp_cmd(8'h80) || got[g0+1] !== exp_cmd(8'h82)) begin miscompares++; $display("FAIL abort_restart: n %0d got %h %h exp 2 %h %h", got.size() - g0, got[g0], got[g0+1], exp_cmd(8'h80), exp_cmd(8'h82)); end
        vectors++; if (done_n - d0 != 1) begin miscompares++; $display("FAIL abort_restart_done: got %0d exp 1", done_n - d0); end
    endtask

    task automatic test_reset_mid;
        int d0 = done_n, a0 = ack_n;
        exe_ready = 1'b0;
        pulse_start(8'h30, 8'd4);
        tick(4);
        i_rst = 1'b1;
        #1;
        vectors++; if ({seq_busy, exe_valid, cmd_rd_en} !== 3'b000) begin miscompares++; $display("FAIL rst_mid: busy,valid,rd_en got %b exp 000", {seq_busy, exe_valid, cmd_rd_en}); end
        tick(2);
        i_rst = 1'b0;
        tick(5);
        vectors++; if (done_n != d0 || ack_n != a0) begin miscompares++; $display("FAIL rst_mid_pulses: done %0d ack %0d exp 0 0", done_n - d0, ack_n - a0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_wrap();
        test_backpressure();
        test_retry();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
